// File: rtl/common_pkg.sv
// Shared core types: data/instruction words, warp pipeline states, fetcher states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package common_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] instr_t;

    // Warp pipeline states driven by the scheduler.
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    // Instruction fetcher states, observed by the scheduler to advance the warp.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DONE = 2'd2
    } fetcher_state_t;

endpackage

// File: rtl/instr_fetcher.sv
// Per-core instruction fetch: reads program memory at the warp PC and holds the word for decode.
// Latency: 1 cycle on a last-fetch buffer hit, otherwise 1 cycle after the memory handshake.
// Backpressure: request held until mem_read_ready; withdrawn/retried on timeout, sticky error when retries run out.
module instr_fetcher
    import common_pkg::*;
#(
    parameter int PMEM_ADDR_BITS = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 3,
    parameter bit REUSE_EN       = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  warp_state_t               warp_state,
    input  data_t                     pc,
    output logic                      mem_read_valid,
    output logic [PMEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                      mem_read_ready,
    input  instr_t                    mem_read_data,
    output fetcher_state_t            fetcher_state,
    output instr_t                    instr,
    output logic                      fetch_error
);

    localparam int TMO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);

    fetcher_state_t      state;
    fetcher_state_t      state_nxt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [RETRY_W-1:0]  retry_cnt;
    data_t               req_pc;      // pc sampled at launch; the live pc may move while in flight
    logic                buf_vld;
    data_t               buf_tag;

    logic hit;
    logic launch;
    logic capture;
    logic withdraw;
    logic rearm;
    logic give_up;
    logic tick;

    assign fetcher_state = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        capture   = 1'b0;
        withdraw  = 1'b0;
        rearm     = 1'b0;
        give_up   = 1'b0;
        tick      = 1'b0;
        hit       = REUSE_EN && buf_vld && (buf_tag == pc);
        case (state)
            FETCH_IDLE: begin
                if (warp_state == WARP_FETCH) begin
                    if (hit) begin
                        state_nxt = FETCH_DONE;
                    end else begin
                        launch    = 1'b1;
                        state_nxt = FETCH_REQ;
                    end
                end
            end
            FETCH_REQ: begin
                if (!mem_read_valid) begin
                    // one-cycle gap after a withdraw; any ready seen here is stale
                    rearm = 1'b1;
                end else if (mem_read_ready) begin
                    capture   = 1'b1;
                    state_nxt = FETCH_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    if (retry_cnt == RETRY_LAST) begin
                        give_up   = 1'b1;
                        state_nxt = FETCH_IDLE;
                    end else begin
                        withdraw = 1'b1;
                    end
                end else begin
                    tick = 1'b1;
                end
            end
            FETCH_DONE: begin
                if (warp_state == WARP_DECODE) begin
                    state_nxt = FETCH_IDLE;
                end
            end
            default: begin
                state_nxt = FETCH_IDLE;
            end
        endcase
    end

    // Request, capture, last-fetch buffer and timeout/retry bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instr            <= '0;
            fetch_error      <= 1'b0;
            req_pc           <= '0;
            buf_vld          <= 1'b0;
            buf_tag          <= '0;
            tmo_cnt          <= '0;
            retry_cnt        <= '0;
        end else begin
            if (launch) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= pc[PMEM_ADDR_BITS+1:2];
                req_pc           <= pc;
                tmo_cnt          <= '0;
                retry_cnt        <= '0;
            end
            if (capture) begin
                instr          <= mem_read_data;
                buf_tag        <= req_pc;
                buf_vld        <= 1'b1;
                mem_read_valid <= 1'b0;
                retry_cnt      <= '0;
            end
            if (withdraw) begin
                mem_read_valid <= 1'b0;
                retry_cnt      <= retry_cnt + 1'b1;
            end
            if (rearm) begin
                mem_read_valid <= 1'b1;
                tmo_cnt        <= '0;
            end
            if (tick && (tmo_cnt != TMO_LAST)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (give_up) begin
                mem_read_valid <= 1'b0;
                fetch_error    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboarded bench for instr_fetcher: directed fetches, buffer hit/miss, timeout/retry, async reset.
// Latency: n/a.
// Backpressure: bench memory model with programmable ready latency or a dead port.
module tb_instr_fetcher;
    import common_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    warp_state_t    warp_state;
    data_t          pc;
    logic           mem_read_valid;
    logic [7:0]     mem_read_address;
    logic           mem_read_ready;
    instr_t         mem_read_data;
    fetcher_state_t fetcher_state;
    instr_t         instr;
    logic           fetch_error;

    // Reference instance without the reuse path, backed by an always-ready memory.
    logic           mem_read_valid1;
    logic [7:0]     mem_read_address1;
    logic           mem_read_ready1;
    instr_t         mem_read_data1;
    fetcher_state_t fetcher_state1;
    instr_t         instr1;
    logic           fetch_error1;

    assign mem_read_ready1 = mem_read_valid1;
    assign mem_read_data1  = {24'h5A5A5A, mem_read_address1};

    int vectors     = 0;
    int miscompares = 0;
    int hs_count    = 0;
    int hs1_count   = 0;
    int mem_lat     = 0;
    bit mem_dead    = 1'b0;
    bit ready_early = 1'b0;

    logic [7:0] exp_req[$];
    instr_t     exp_done[$];

    instr_fetcher #(
        .PMEM_ADDR_BITS(8), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2), .REUSE_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .warp_state(warp_state), .pc(pc),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .fetcher_state(fetcher_state), .instr(instr), .fetch_error(fetch_error)
    );

    instr_fetcher #(
        .PMEM_ADDR_BITS(8), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2), .REUSE_EN(1'b0)
    ) dut_noreuse (
        .clk(clk), .reset(reset), .warp_state(warp_state), .pc(pc),
        .mem_read_valid(mem_read_valid1), .mem_read_address(mem_read_address1),
        .mem_read_ready(mem_read_ready1), .mem_read_data(mem_read_data1),
        .fetcher_state(fetcher_state1), .instr(instr1), .fetch_error(fetch_error1)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Memory model for the main instance: ready after mem_lat cycles of valid, or never when dead.
    initial begin : responder
        int wcnt;
        wcnt = 0;
        mem_read_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_early) begin
                mem_read_ready = 1'b1;
            end else if (mem_dead || !mem_read_valid) begin
                mem_read_ready = 1'b0;
                wcnt = 0;
            end else begin
                mem_read_ready = (wcnt == mem_lat);
                if (wcnt < mem_lat) wcnt++;
            end
        end
    end

    // Monitor: pops expected request addresses on handshakes and expected words on DONE entry.
    initial begin : monitor
        fetcher_state_t prev;
        prev = FETCH_IDLE;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = FETCH_IDLE;
            end else begin
                if (mem_read_valid && mem_read_ready) begin
                    hs_count++;
                    if (exp_req.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_request: address 0x%02h, none expected", mem_read_address);
                    end else begin
                        check("req_address", 32'(mem_read_address), 32'(exp_req.pop_front()));
                    end
                end
                if (mem_read_valid1 && mem_read_ready1) hs1_count++;
                if (fetcher_state == FETCH_DONE && prev != FETCH_DONE) begin
                    if (exp_done.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: instr 0x%08h, none expected", instr);
                    end else begin
                        check("done_instr", instr, exp_done.pop_front());
                    end
                end
                prev = fetcher_state;
            end
        end
    end

    // One fetch/decode round trip on both instances; pc is scrambled once the request is in flight.
    task automatic do_fetch(input data_t p, input int lat, input instr_t word,
                            input bit exp_mem, input instr_t exp_instr);
        int h0;
        int h1;
        int done_at;
        bit both;
        pc = p;
        mem_lat = lat;
        mem_read_data = word;
        if (exp_mem) exp_req.push_back(p[9:2]);
        exp_done.push_back(exp_instr);
        h0 = hs_count;
        h1 = hs1_count;
        done_at = 0;
        both = 1'b0;
        warp_state = WARP_FETCH;
        for (int it = 1; it <= 60 && !both; it++) begin
            @(posedge clk);
            #1;
            if (it == 1) pc = ~p;
            if (fetcher_state == FETCH_DONE && done_at == 0) done_at = it;
            both = (fetcher_state == FETCH_DONE) && (fetcher_state1 == FETCH_DONE);
        end
        if (!both) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: pc 0x%08h state %0d/%0d, expected DONE", p, fetcher_state, fetcher_state1);
        end
        check("done_latency", done_at, exp_mem ? lat + 2 : 1);
        check("mem_handshakes", hs_count - h0, exp_mem ? 1 : 0);
        check("ref_handshakes", hs1_count - h1, 1);
        check("ref_instr", instr1, {24'h5A5A5A, p[9:2]});
        warp_state = WARP_DECODE;
        @(posedge clk);
        #1;
        warp_state = WARP_IDLE;
        check("decode_exit", 32'(fetcher_state), 32'(FETCH_IDLE));
        check("instr_hold", instr, exp_instr);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [25:0] pat;
        logic [25:0] exp_pat;
        reset = 1'b0;
        warp_state = WARP_IDLE;
        pc = '0;
        mem_read_data = '0;

        // Reset must dominate even with a fetch requested.
        repeat (2) @(posedge clk);
        #1;
        pc = 32'h10;
        warp_state = WARP_FETCH;
        @(posedge clk);
        #1;
        check("rst_state", 32'(fetcher_state), 32'(FETCH_IDLE));
        check("rst_valid", 32'(mem_read_valid), 32'd0);
        check("rst_address", 32'(mem_read_address), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_error", 32'(fetch_error), 32'd0);
        warp_state = WARP_IDLE;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_fetch(32'h10, 3, 32'h00A00093, 1'b1, 32'h00A00093); // normal fetch, address 4
        do_fetch(32'h10, 3, 32'hFFFFFFFF, 1'b0, 32'h00A00093); // buffer hit
        do_fetch(32'h14, 1, 32'h00100113, 1'b1, 32'h00100113); // miss, address 5
        do_fetch(32'h14, 1, 32'hFFFFFFFF, 1'b0, 32'h00100113); // hit on updated tag
        do_fetch(32'h10, 2, 32'h12345678, 1'b1, 32'h12345678); // old tag evicted

        // Dead memory: 3 attempts of 8 valid cycles separated by 1-cycle gaps, then error.
        mem_dead = 1'b1;
        pc = 32'h20;
        warp_state = WARP_FETCH;
        @(posedge clk);
        #1;
        warp_state = WARP_IDLE;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            pat[i] = mem_read_valid;
            exp_pat[i] = !(i == 8 || i == 17);
        end
        check("timeout_pattern", 32'(pat), 32'(exp_pat));
        check("error_early", 32'(fetch_error), 32'd0);
        @(negedge clk);
        check("error_set", 32'(fetch_error), 32'd1);
        check("error_valid", 32'(mem_read_valid), 32'd0);
        check("error_state", 32'(fetcher_state), 32'(FETCH_IDLE));
        check("retry_address", 32'(mem_read_address), 32'h08);
        mem_dead = 1'b0;
        warp_state = WARP_DECODE;
        @(posedge clk);
        #1;
        warp_state = WARP_IDLE;

        do_fetch(32'h18, 1, 32'h00300193, 1'b1, 32'h00300193);
        check("error_sticky", 32'(fetch_error), 32'd1);

        // Asynchronous reset while a request is outstanding.
        mem_dead = 1'b1;
        pc = 32'h1C;
        warp_state = WARP_FETCH;
        @(posedge clk);
        #1;
        warp_state = WARP_IDLE;
        @(posedge clk);
        #3;
        check("req_active", 32'(mem_read_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(mem_read_valid), 32'd0);
        check("arst_state", 32'(fetcher_state), 32'(FETCH_IDLE));
        check("arst_instr", instr, 32'd0);
        check("arst_error", 32'(fetch_error), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_dead = 1'b0;
        @(posedge clk);
        #1;
        do_fetch(32'h18, 0, 32'h00400213, 1'b1, 32'h00400213); // buffer was invalidated

        // Ready already high when valid rises.
        ready_early = 1'b1;
        @(posedge clk);
        #1;
        do_fetch(32'h24, 0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
        ready_early = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("req_queue_empty", exp_req.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
